// File: rtl/test1_mon.sv
// Monitors the untimed test1 signal: synchronises and deglitches it, counts
// filtered rising edges and reports each high-pulse width through a valid/ready handshake.
module test1_mon #(
  parameter int CNT_W = 16,
  parameter int FILT  = 2
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             test1,
  input  logic             clr,
  input  logic             meas_ready,
  output logic             meas_valid,
  output logic [CNT_W-1:0] meas_width,
  output logic             meas_ovf,
  output logic             meas_drop,
  output logic [CNT_W-1:0] edge_cnt,
  output logic             level
);

  localparam logic [1:0]       ST_IDLE     = 2'd0;
  localparam logic [1:0]       ST_MEAS     = 2'd1;
  localparam logic [1:0]       ST_WAIT_LOW = 2'd2;
  localparam logic [3:0]       FILT_LAST   = 4'(FILT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

  logic [1:0]       sync_reg;
  logic [3:0]       filt_cnt_reg, filt_cnt_next;
  logic             level_reg, level_next;
  logic [1:0]       state_reg, state_next;
  logic [CNT_W-1:0] width_cnt_reg, width_cnt_next;
  logic             ovf_reg, ovf_next;
  logic [CNT_W-1:0] edge_cnt_reg, edge_cnt_next;
  logic             valid_reg, valid_next;
  logic [CNT_W-1:0] width_out_reg, width_out_next;
  logic             ovf_out_reg, ovf_out_next;
  logic             drop_reg, drop_next;

  logic sync;
  logic toggle;
  logic rise;
  logic fall;
  logic load;

  always_comb begin
    sync           = sync_reg[1];
    toggle         = (sync != level_reg) && (filt_cnt_reg == FILT_LAST);
    rise           = toggle && !level_reg;
    fall           = toggle && level_reg;
    filt_cnt_next  = ((sync == level_reg) || toggle) ? 4'd0 : filt_cnt_reg + 4'd1;
    level_next     = level_reg ^ toggle;

    load           = 1'b0;
    state_next     = state_reg;
    width_cnt_next = width_cnt_reg;
    ovf_next       = ovf_reg;
    edge_cnt_next  = edge_cnt_reg;
    valid_next     = valid_reg;
    width_out_next = width_out_reg;
    ovf_out_next   = ovf_out_reg;
    drop_next      = drop_reg;

    if (clr) begin
      // Decide on the post-edge level so the FSM never waits for a fall that already happened.
      state_next     = level_next ? ST_WAIT_LOW : ST_IDLE;
      width_cnt_next = '0;
      ovf_next       = 1'b0;
      edge_cnt_next  = '0;
      valid_next     = 1'b0;
      width_out_next = '0;
      ovf_out_next   = 1'b0;
      drop_next      = 1'b0;
    end else begin
      if (rise)
        edge_cnt_next = edge_cnt_reg + CNT_W'(1);

      case (state_reg)
        ST_IDLE: begin
          if (rise) begin
            state_next     = ST_MEAS;
            width_cnt_next = CNT_W'(1);
            ovf_next       = 1'b0;
          end
        end
        ST_MEAS: begin
          if (fall) begin
            state_next = ST_IDLE;
            load       = 1'b1;
          end else if (level_reg) begin
            if (width_cnt_reg == CNT_MAX)
              ovf_next = 1'b1;
            else
              width_cnt_next = width_cnt_reg + CNT_W'(1);
          end
        end
        ST_WAIT_LOW: begin
          if (fall)
            state_next = ST_IDLE;
        end
        default: state_next = ST_IDLE;
      endcase

      // A freshly completed pulse always replaces the held result.
      if (load) begin
        valid_next     = 1'b1;
        width_out_next = width_cnt_reg;
        ovf_out_next   = ovf_reg;
        if (valid_reg && !meas_ready)
          drop_next = 1'b1;
      end else if (valid_reg && meas_ready) begin
        valid_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      sync_reg      <= 2'b00;
      filt_cnt_reg  <= 4'd0;
      level_reg     <= 1'b0;
      state_reg     <= ST_IDLE;
      width_cnt_reg <= '0;
      ovf_reg       <= 1'b0;
      edge_cnt_reg  <= '0;
      valid_reg     <= 1'b0;
      width_out_reg <= '0;
      ovf_out_reg   <= 1'b0;
      drop_reg      <= 1'b0;
    end else begin
      sync_reg      <= {sync_reg[0], test1};
      filt_cnt_reg  <= filt_cnt_next;
      level_reg     <= level_next;
      state_reg     <= state_next;
      width_cnt_reg <= width_cnt_next;
      ovf_reg       <= ovf_next;
      edge_cnt_reg  <= edge_cnt_next;
      valid_reg     <= valid_next;
      width_out_reg <= width_out_next;
      ovf_out_reg   <= ovf_out_next;
      drop_reg      <= drop_next;
    end
  end

  assign meas_valid = valid_reg;
  assign meas_width = width_out_reg;
  assign meas_ovf   = ovf_out_reg;
  assign meas_drop  = drop_reg;
  assign edge_cnt   = edge_cnt_reg;
  assign level      = level_reg;

endmodule

// File: tb/tb_test1_mon.sv
// Randomised and directed bench for test1_mon against a pulse-level reference model.
module tb_test1_mon;
  localparam int      CNT_W = 16;
  localparam int      FILT  = 2;
  localparam longint  CMAX  = (longint'(1) << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rstb = 1'b0;
  logic             test1 = 1'b0;
  logic             clr = 1'b0;
  logic             meas_ready = 1'b0;
  logic             meas_valid;
  logic [CNT_W-1:0] meas_width;
  logic             meas_ovf;
  logic             meas_drop;
  logic [CNT_W-1:0] edge_cnt;
  logic             level;

  test1_mon #(.CNT_W(CNT_W), .FILT(FILT)) dut (
    .clk(clk), .rstb(rstb), .test1(test1), .clr(clr), .meas_ready(meas_ready),
    .meas_valid(meas_valid), .meas_width(meas_width), .meas_ovf(meas_ovf),
    .meas_drop(meas_drop), .edge_cnt(edge_cnt), .level(level)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      if (miscompares <= 40)
        $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: signal history and pulse start/stop times
  bit     m_s1, m_s2, m_level, m_meas, m_valid, m_ovf, m_drop;
  bit     hist[$];
  longint m_cyc, m_start, m_edge, m_width;

  task automatic model_step();
    bit sync, all_diff, toggled, rise, fall;
    longint n;
    if (!rstb) begin
      m_s1 = 0; m_s2 = 0; m_level = 0; m_meas = 0; hist.delete();
      m_valid = 0; m_ovf = 0; m_drop = 0; m_edge = 0; m_width = 0;
      return;
    end
    m_cyc++;
    sync = m_s2;
    m_s2 = m_s1;
    m_s1 = test1;
    hist.push_back(sync);
    if (hist.size() > 64) void'(hist.pop_front());
    toggled = 0;
    if (hist.size() >= FILT) begin
      all_diff = 1;
      for (int i = 0; i < FILT; i++)
        if (hist[hist.size() - 1 - i] == m_level) all_diff = 0;
      toggled = all_diff;
    end
    if (toggled) hist.delete();
    rise = toggled && !m_level;
    fall = toggled && m_level;
    if (toggled) m_level = !m_level;

    if (clr) begin
      m_edge = 0; m_valid = 0; m_width = 0; m_ovf = 0; m_drop = 0; m_meas = 0;
    end else begin
      if (rise) begin
        m_edge  = (m_edge + 1) & CMAX;
        m_meas  = 1;
        m_start = m_cyc;
      end
      if (fall && m_meas) begin
        n = m_cyc - m_start;
        if (m_valid && !meas_ready) m_drop = 1;
        m_valid = 1;
        m_width = (n > CMAX) ? CMAX : n;
        m_ovf   = (n > CMAX);
        m_meas  = 0;
      end else if (m_valid && meas_ready) begin
        m_valid = 0;
      end
    end
  endtask

  task automatic compare_all();
    check("level", level, m_level);
    check("edge_cnt", edge_cnt, m_edge);
    check("meas_valid", meas_valid, m_valid);
    check("meas_width", meas_width, m_width);
    check("meas_ovf", meas_ovf, m_ovf);
    check("meas_drop", meas_drop, m_drop);
  endtask

  task automatic cycle(input bit t1, input bit c, input bit r);
    test1 = t1; clr = c; meas_ready = r;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  int     vcnt;
  longint cap_w;
  bit     cap_ovf, saw_level;

  task automatic clear_cap();
    vcnt = 0; cap_w = 0; cap_ovf = 0; saw_level = 0;
  endtask

  task automatic run(input int n, input bit t1, input bit r);
    for (int i = 0; i < n; i++) begin
      cycle(t1, 1'b0, r);
      if (meas_valid) begin
        vcnt++; cap_w = meas_width; cap_ovf = meas_ovf;
      end
      if (level) saw_level = 1;
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_level"}, level, 0);
    check({tag, "_edge"}, edge_cnt, 0);
    check({tag, "_valid"}, meas_valid, 0);
    check({tag, "_width"}, meas_width, 0);
    check({tag, "_ovf"}, meas_ovf, 0);
    check({tag, "_drop"}, meas_drop, 0);
  endtask

  initial begin
    int rise_idx;
    bit lvl;
    int len;

    rstb = 1'b0;
    #1 check_zero("por");
    @(negedge clk);
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    rstb = 1'b1;
    run(10, 0, 1);

    // Basic 5-cycle pulse
    clear_cap();
    rise_idx = 0;
    for (int i = 1; i <= 5; i++) begin
      cycle(1, 0, 1);
      if (meas_valid) vcnt++;
      if (level && rise_idx == 0) rise_idx = i;
    end
    run(12, 0, 1);
    check("rise_latency", rise_idx, 2 + FILT);
    check("p5_valid_cycles", vcnt, 1);
    check("p5_width", cap_w, 5);
    check("p5_ovf", cap_ovf, 0);
    check("p5_edge", edge_cnt, 1);

    // Glitch shorter than the filter
    clear_cap();
    run(1, 1, 1);
    run(10, 0, 1);
    check("glitch_level", saw_level, 0);
    check("glitch_valid", vcnt, 0);
    check("glitch_edge", edge_cnt, 1);

    // Overwrite of an unconsumed result
    cycle(0, 1, 0);
    run(3, 1, 0);
    run(8, 0, 0);
    run(7, 1, 0);
    run(8, 0, 0);
    check("drop_valid", meas_valid, 1);
    check("drop_width", meas_width, 7);
    check("drop_flag", meas_drop, 1);
    check("drop_edge", edge_cnt, 2);
    run(1, 0, 1);
    check("drop_consumed", meas_valid, 0);
    check("drop_sticky", meas_drop, 1);

    // Clear in the middle of a high pulse
    cycle(0, 1, 1);
    clear_cap();
    run(6, 1, 1);
    check("clr_level_high", level, 1);
    cycle(1, 1, 1);
    check("clr_edge", edge_cnt, 0);
    check("clr_valid", meas_valid, 0);
    run(4, 1, 1);
    run(8, 0, 1);
    check("clr_no_result", vcnt, 0);
    check("clr_edge_after", edge_cnt, 0);
    clear_cap();
    run(4, 1, 1);
    run(8, 0, 1);
    check("post_clr_valid", vcnt, 1);
    check("post_clr_width", cap_w, 4);
    check("post_clr_edge", edge_cnt, 1);

    // Width saturation
    clear_cap();
    run(70000, 1, 1);
    run(8, 0, 1);
    check("sat_width", cap_w, (70000 > CMAX) ? CMAX : 70000);
    check("sat_ovf", cap_ovf, 1);

    // Reset during a pulse
    clear_cap();
    run(3, 1, 1);
    rstb = 1'b0;
    #1 check_zero("rst_async");
    run(2, 1, 1);
    rstb = 1'b1;
    run(6, 1, 1);
    run(8, 0, 1);
    check("rst_valid", vcnt, 1);
    check("rst_width", cap_w, 6);
    check("rst_edge", edge_cnt, 1);

    // Random runs of test1 with random handshake, clears and resets
    for (int k = 0; k < 600; k++) begin
      lvl = $urandom_range(0, 1);
      len = $urandom_range(1, 9);
      for (int j = 0; j < len; j++) begin
        if ($urandom_range(0, 999) == 0) rstb = 1'b0;
        cycle(lvl, $urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0);
        rstb = 1'b1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
